// File: rtl/axi_stream_pkt_arb.sv
// Packet-atomic round-robin arbiter: N AXI-stream sources share one sink.
// Once a multi-beat packet starts, its owner keeps the output until its eop
// beat is accepted, so beats of different packets never interleave.
// A single output register decouples o_axi timing from the inputs.
//
// Handshake: a beat moves on a port in the cycle where val and rdy are both
// high at the rising clock edge. A source holds val and its fields stable
// until that happens. o_axi keeps dat/mod/sop/eop stable while val=1 and rdy=0.
module axi_stream_pkt_arb #(
    parameter  int N          = 3,
    parameter  int DAT_BYTS   = 8,
    parameter  int CTR_BITS   = 16,
    localparam int MOD_BITS   = $clog2(DAT_BYTS),
    localparam int DW         = DAT_BYTS * 8,
    localparam int GRANT_BITS = $clog2(N)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // requester streams, source i occupies slice i of each bus
    input  logic [N*DW-1:0]       i_axi_dat,
    input  logic [N*MOD_BITS-1:0] i_axi_mod,
    input  logic [N-1:0]          i_axi_val,
    input  logic [N-1:0]          i_axi_sop,
    input  logic [N-1:0]          i_axi_eop,
    output logic [N-1:0]          i_axi_rdy,
    // arbitrated stream
    output logic [DW-1:0]         o_axi_dat,
    output logic [MOD_BITS-1:0]   o_axi_mod,
    output logic                  o_axi_val,
    output logic                  o_axi_sop,
    output logic                  o_axi_eop,
    input  logic                  o_axi_rdy,
    // status
    output logic [GRANT_BITS-1:0] o_grant,
    output logic                  o_locked,
    output logic [N*CTR_BITS-1:0] o_pkt_cnt,
    output logic                  o_err,
    output logic                  o_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [GRANT_BITS-1:0] ptr;
    logic [GRANT_BITS-1:0] sel;
    logic [GRANT_BITS-1:0] src;
    logic                  found;
    int                    idx;
    logic                  space;
    logic                  accept;
    logic [DW-1:0]         beat_dat;
    logic [MOD_BITS-1:0]   beat_mod;
    logic                  beat_sop;
    logic                  beat_eop;

    // Next requester after i in round-robin order.
    function automatic logic [GRANT_BITS-1:0] wrap_inc(input logic [GRANT_BITS-1:0] i);
        if (int'(i) >= N - 1) return '0;
        return i + 1'b1;
    endfunction

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && i_axi_val[idx]) begin
                found = 1'b1;
                sel   = idx[GRANT_BITS-1:0];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign space  = ~o_axi_val | o_axi_rdy;
    // While locked only the owner may move; otherwise the round-robin winner.
    assign src    = (state == LOCKED) ? o_grant : sel;
    assign accept = ~i_rst & space & i_axi_val[src];

    // In IDLE rdy is offered only when someone actually requests, so idle
    // sources never see a stray rdy. During reset nobody is ready.
    assign i_axi_rdy = (~i_rst & space & ((state == LOCKED) | found))
                       ? (N'(1) << src) : '0;

    assign beat_dat = i_axi_dat[src*DW +: DW];
    assign beat_mod = i_axi_mod[src*MOD_BITS +: MOD_BITS];
    assign beat_sop = i_axi_sop[src];
    assign beat_eop = i_axi_eop[src];

    assign o_state = state;

    // Next-state logic: lock on a non-final beat, unlock on an accepted eop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept && !beat_eop) state_nxt = LOCKED;
            LOCKED: if (accept && beat_eop)  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Output register, grant/pointer bookkeeping and sticky framing error.
    // Reset drops any partial packet: val clears and no eop is ever emitted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_axi_val <= 1'b0;
            o_axi_sop <= 1'b0;
            o_axi_eop <= 1'b0;
            o_axi_dat <= '0;
            o_axi_mod <= '0;
            o_grant   <= '0;
            o_locked  <= 1'b0;
            ptr       <= '0;
            o_err     <= 1'b0;
        end else begin
            if (accept) begin
                o_axi_val <= 1'b1;
                o_axi_sop <= beat_sop;
                o_axi_eop <= beat_eop;
                o_axi_dat <= beat_dat;
                o_axi_mod <= beat_mod;
                o_grant   <= src;
                o_locked  <= (state_nxt == LOCKED);
                if (beat_eop) ptr <= wrap_inc(src);
                // A packet must open with sop; the beat is still forwarded.
                if (state == IDLE && !beat_sop) o_err <= 1'b1;
            end else if (o_axi_rdy) begin
                o_axi_val <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt
        logic [CTR_BITS-1:0] cnt;

        // Per-requester packet counter, bumped on each accepted eop, wraps.
        always_ff @(posedge i_clk) begin
            if (i_rst)
                cnt <= '0;
            else if (accept && beat_eop && src == GRANT_BITS'(g))
                cnt <= cnt + 1'b1;
        end

        assign o_pkt_cnt[g*CTR_BITS +: CTR_BITS] = cnt;
    end

endmodule

// File: tb/tb_axi_stream_pkt_arb.sv
// Bench for axi_stream_pkt_arb (N=3, 8-byte beats): a table of single-beat
// arbitration steps, directed packet sequences, and randomized traffic judged
// by a packet-level model (accept-order scoreboard, no-interleave, per-source
// round-robin wait bound, packet counts).
module tb_axi_stream_pkt_arb;

    localparam int N  = 3;
    localparam int DB = 8;
    localparam int DW = DB * 8;
    localparam int MB = 3;
    localparam int CW = 16;
    localparam int BW = DW + MB + 2;   // {sop, eop, mod, dat}

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] in_dat;
    logic [N*MB-1:0] in_mod;
    logic [N-1:0]    in_val, in_sop, in_eop, in_rdy;
    logic [DW-1:0]   out_dat;
    logic [MB-1:0]   out_mod;
    logic            out_val, out_sop, out_eop, out_rdy;
    logic [1:0]      grant;
    logic            locked;
    logic [N*CW-1:0] pkt_cnt;
    logic            err;
    logic            state_dbg;

    always #5 clk = ~clk;

    axi_stream_pkt_arb #(.N(N), .DAT_BYTS(DB), .CTR_BITS(CW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_axi_dat (in_dat),
        .i_axi_mod (in_mod),
        .i_axi_val (in_val),
        .i_axi_sop (in_sop),
        .i_axi_eop (in_eop),
        .i_axi_rdy (in_rdy),
        .o_axi_dat (out_dat),
        .o_axi_mod (out_mod),
        .o_axi_val (out_val),
        .o_axi_sop (out_sop),
        .o_axi_eop (out_eop),
        .o_axi_rdy (out_rdy),
        .o_grant   (grant),
        .o_locked  (locked),
        .o_pkt_cnt (pkt_cnt),
        .o_err     (err),
        .o_state   (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [BW-1:0] mem [N][64];
    int            len [N];
    int            pos [N];
    int            delay [N];
    int            cnt_exp [N];
    int            passed [N];
    logic [N-1:0]  fired;
    bit            gap_en;
    bit            rdy_rand;
    bit            owner_busy;
    int            owner;
    bit            prev_stall;
    logic [BW-1:0] prev_word;
    logic [BW+1:0] exp_q [$];   // {source, beat} in accept order
    int            out_log [$]; // source of each beat leaving o_axi

    typedef struct packed {
        logic [2:0] val;
        logic       ordy;
        logic [2:0] exp_rdy;
        logic       exp_oval;
        logic [1:0] exp_grant;
    } vec_t;
    vec_t vec [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst      = 1'b1;
        in_val   = '0;
        in_sop   = '0;
        in_eop   = '0;
        in_dat   = '0;
        in_mod   = '0;
        out_rdy  = 1'b1;
        gap_en   = 1'b0;
        rdy_rand = 1'b0;
        fired    = '0;
        owner_busy = 1'b0;
        owner    = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        exp_q.delete();
        out_log.delete();
        for (int s = 0; s < N; s++) begin
            len[s] = 0; pos[s] = 0; delay[s] = 0; cnt_exp[s] = 0; passed[s] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic add_beat(input int s, input logic sop, input logic eop,
                            input logic [MB-1:0] mod, input logic [DW-1:0] dat);
        mem[s][len[s]] = {sop, eop, mod, dat};
        len[s]++;
    endtask

    task automatic add_pkt(input int s, input int nb);
        for (int b = 0; b < nb; b++)
            add_beat(s, b == 0, b == nb - 1, MB'($urandom_range(0, 7)),
                     {8'(s), 24'(len[s]), $urandom()});
    endtask

    task automatic drive_src(input int s, input logic sop, input logic eop, input logic [DW-1:0] dat);
        in_val = '0;
        in_val[s] = 1'b1;
        in_sop[s] = sop;
        in_eop[s] = eop;
        in_dat[s*DW +: DW] = dat;
        in_mod[s*MB +: MB] = '0;
    endtask

    // Drive all sources, sample handshakes at negedge, score both sides.
    task automatic run_traffic(input int budget);
        int            cyc;
        bit            done;
        logic [BW-1:0] w;
        logic [BW-1:0] cur;
        logic [BW+1:0] head;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < N; s++) begin
                if (delay[s] > 0) begin
                    delay[s]--;
                    in_val[s] = 1'b0;
                end else if (in_val[s] && !fired[s]) begin
                    in_val[s] = 1'b1;
                end else if (pos[s] < len[s]) begin
                    w = mem[s][pos[s]];
                    in_val[s] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                    in_dat[s*DW +: DW] = w[DW-1:0];
                    in_mod[s*MB +: MB] = w[DW+MB-1:DW];
                    in_sop[s] = w[BW-1];
                    in_eop[s] = w[BW-2];
                end else begin
                    in_val[s] = 1'b0;
                end
            end
            out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

            @(negedge clk);
            fired = in_val & in_rdy;
            check("rdy_onehot", $countones(in_rdy) <= 1, 1);

            cur = {out_sop, out_eop, out_mod, out_dat};
            if (out_val) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_unexpected");
                end else begin
                    head = exp_q[0];
                    check("out_grant", grant, head[BW+1:BW]);
                    if (prev_stall) check("out_hold", cur, prev_word);
                    if (out_rdy) begin
                        check("out_beat", cur, head[BW-1:0]);
                        out_log.push_back(int'(head[BW+1:BW]));
                        void'(exp_q.pop_front());
                    end
                end
            end else if (prev_stall) begin
                fail_now("out_dropped_while_stalled");
            end
            prev_stall = out_val & ~out_rdy;
            prev_word  = cur;

            for (int s = 0; s < N; s++) begin
                if (fired[s]) begin
                    w = mem[s][pos[s]];
                    if (owner_busy) check("no_interleave", s, owner);
                    else passed[s] = 0;
                    exp_q.push_back({2'(s), w});
                    if (w[BW-2]) begin
                        cnt_exp[s]++;
                        owner_busy = 1'b0;
                        for (int o = 0; o < N; o++) begin
                            if (o != s && in_val[o]) begin
                                passed[o]++;
                                check("rr_wait_bound", passed[o] <= N - 1, 1);
                            end
                        end
                    end else begin
                        owner_busy = 1'b1;
                        owner = s;
                    end
                    pos[s]++;
                end
            end

            done = (exp_q.size() == 0) && !out_val;
            for (int s = 0; s < N; s++) if (pos[s] < len[s]) done = 1'b0;
            cyc++;
        end
        if (!done) fail_now("traffic_timeout");
        @(posedge clk);
        #1 in_val = '0;
        for (int s = 0; s < N; s++)
            check("pkt_cnt", pkt_cnt[s*CW +: CW], cnt_exp[s][CW-1:0]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int es;
        int before2;
        // Single-beat steps from reset: {val, o_rdy, exp rdy, exp o_val after edge, exp grant after edge}
        vec[0]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
        vec[1]  = '{3'b110, 1'b1, 3'b010, 1'b1, 2'd1};
        vec[2]  = '{3'b110, 1'b1, 3'b100, 1'b1, 2'd2};
        vec[3]  = '{3'b110, 1'b0, 3'b000, 1'b1, 2'd2};
        vec[4]  = '{3'b011, 1'b1, 3'b001, 1'b1, 2'd0};
        vec[5]  = '{3'b011, 1'b1, 3'b010, 1'b1, 2'd1};
        vec[6]  = '{3'b011, 1'b1, 3'b001, 1'b1, 2'd0};
        vec[7]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
        vec[8]  = '{3'b100, 1'b0, 3'b100, 1'b1, 2'd2};
        vec[9]  = '{3'b000, 1'b0, 3'b000, 1'b1, 2'd2};
        vec[10] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd2};

        do_reset();

        // Reset state
        check("rst_oval", out_val, 0);
        check("rst_grant", grant, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        @(negedge clk);
        check("rst_rdy", in_rdy, 0);
        @(posedge clk);
        #1;

        // Table-driven arbitration steps
        for (int i = 0; i < 11; i++) begin
            in_val  = vec[i].val;
            in_sop  = '1;
            in_eop  = '1;
            out_rdy = vec[i].ordy;
            for (int s = 0; s < N; s++) in_dat[s*DW +: DW] = {56'(i), 8'(s)};
            @(negedge clk);
            check("vec_rdy", in_rdy, vec[i].exp_rdy);
            @(posedge clk);
            #1;
            check("vec_oval", out_val, vec[i].exp_oval);
            check("vec_grant", grant, vec[i].exp_grant);
            if (vec[i].exp_rdy != 0) begin
                es = 0;
                for (int s = 0; s < N; s++) if (vec[i].exp_rdy[s]) es = s;
                check("vec_dat", out_dat, {56'(i), 8'(es)});
            end
        end
        in_val = '0;
        check("vec_cnt0", pkt_cnt[0*CW +: CW], 2);
        check("vec_cnt1", pkt_cnt[1*CW +: CW], 2);
        check("vec_cnt2", pkt_cnt[2*CW +: CW], 2);

        // Three simultaneous 3-beat packets: order 0,1,2, no interleave
        do_reset();
        for (int s = 0; s < N; s++) add_pkt(s, 3);
        run_traffic(200);
        check("seq3_beats", out_log.size(), 9);
        if (out_log.size() == 9)
            for (int k = 0; k < 9; k++) check("seq3_order", out_log[k], k / 3);

        // Fairness: src1 streams single-beat packets, src2 one 2-beat packet
        do_reset();
        for (int p = 0; p < 8; p++) add_pkt(1, 1);
        add_pkt(2, 2);
        run_traffic(200);
        before2 = 0;
        es = 0;
        foreach (out_log[k]) begin
            if (out_log[k] == 2) es = 1;
            if (!es && out_log[k] == 1) before2++;
        end
        check("rr_src1_before_src2", before2, 1);
        if (out_log.size() >= 4) begin
            check("rr_seq0", out_log[0], 1);
            check("rr_seq1", out_log[1], 2);
            check("rr_seq2", out_log[2], 2);
            check("rr_seq3", out_log[3], 1);
        end else begin
            fail_now("rr_too_few_beats");
        end

        // Random back-pressure on a 4-beat packet; src0 arrives mid-packet
        do_reset();
        rdy_rand = 1'b1;
        add_beat(1, 1'b1, 1'b0, 3'd0, 64'h1111_1111_1111_1111);
        add_beat(1, 1'b0, 1'b0, 3'd0, 64'h2222_2222_2222_2222);
        add_beat(1, 1'b0, 1'b0, 3'd0, 64'h3333_3333_3333_3333);
        add_beat(1, 1'b0, 1'b1, 3'd5, 64'h4444_4444_4444_4444);
        add_pkt(0, 2);
        delay[0] = 2;
        run_traffic(400);
        check("bp_beats", out_log.size(), 6);
        if (out_log.size() == 6)
            for (int k = 0; k < 6; k++) check("bp_order", out_log[k], (k < 4) ? 1 : 0);

        // Reset in the middle of a 4-beat packet
        do_reset();
        out_rdy = 1'b1;
        drive_src(0, 1'b1, 1'b1, 64'hA5);
        @(posedge clk);
        #1;
        check("mid_pre_cnt", pkt_cnt[0 +: CW], 1);
        drive_src(0, 1'b1, 1'b0, 64'h1111_1111_1111_1111);
        @(posedge clk);
        #1;
        check("mid_locked", locked, 1);
        check("mid_grant", grant, 0);
        drive_src(0, 1'b0, 1'b0, 64'h2222_2222_2222_2222);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", in_rdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_val = '0;
        check("mid_oval", out_val, 0);
        check("mid_unlocked", locked, 0);
        check("mid_cnt", pkt_cnt, 0);
        @(posedge clk);
        #1;
        check("mid_no_eop", out_val, 0);

        // Missing sop on src2: forwarded, sticky error until reset
        do_reset();
        drive_src(2, 1'b0, 1'b1, 64'hDEAD);
        @(posedge clk);
        #1;
        check("nosop_err", err, 1);
        check("nosop_oval", out_val, 1);
        check("nosop_osop", out_sop, 0);
        check("nosop_dat", out_dat, 64'hDEAD);
        drive_src(2, 1'b1, 1'b1, 64'hBEEF);
        @(posedge clk);
        #1;
        in_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("nosop_sticky", err, 1);
        do_reset();
        check("nosop_cleared", err, 0);

        // Randomized traffic
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gap_en   = 1'b1;
            rdy_rand = 1'b1;
            for (int s = 0; s < N; s++) begin
                delay[s] = $urandom_range(0, 3);
                for (int p = 0, np = $urandom_range(4, 6); p < np; p++)
                    add_pkt(s, $urandom_range(1, 5));
            end
            run_traffic(3000);
            check("rand_err", err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
